// File: rtl/br_stat_pkg.sv
// +----------------------------------------------------------------------+
// | br_stat_pkg                                                          |
// | Shared types and constants for the branch statistics monitor.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package br_stat_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [31:0] C_HALT_INSN = 32'h0000_006F;
  localparam logic [31:0] C_NOP_INSN  = 32'h0000_0013;

  function automatic int hist_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/br_sat_counter.sv
// +----------------------------------------------------------------------+
// | br_sat_counter                                                       |
// | Up-counter that sticks at all-ones; reset/clear return it to zero.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module br_sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

`default_nettype wire

// File: rtl/br_stat_monitor.sv
// +----------------------------------------------------------------------+
// | br_stat_monitor                                                      |
// | Branch/fetch performance counters for one program run, frozen at     |
// | halt. Optional miss-PC history ring enabled by macro MISS_HIST_EN.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module br_stat_monitor
  import br_stat_pkg::*;
#(
  parameter int          CNT_WIDTH    = 32,
  parameter logic [31:0] HALT_INSN    = C_HALT_INSN,
  parameter logic [31:0] NOP_INSN     = C_NOP_INSN,
  parameter int          DRAIN_CYCLES = 4,
  parameter int          MISS_DEPTH   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 br_miss_i,
  input  logic                 br_instr_i,
  input  logic [31:0]          instr_i,
  input  logic [31:0]          t_instr_i,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o,
  output logic [CNT_WIDTH-1:0] fetch_cnt_o,
  output logic [CNT_WIDTH-1:0] br_cnt_o,
  output logic [CNT_WIDTH-1:0] miss_cnt_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 done_pulse_o,
`ifdef MISS_HIST_EN
  input  logic [hist_idx_w(MISS_DEPTH)-1:0] hist_idx_i,
  output logic [31:0]          hist_pc_o,
  output logic                 hist_vld_o,
`endif
  output logic                 proto_err_o
);

  localparam int c_DRN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [c_DRN_W-1:0] c_DRAIN_LOAD = c_DRN_W'(DRAIN_CYCLES - 1);

  state_t             r_state, w_state_nxt;
  logic [c_DRN_W-1:0] r_drain, w_drain_nxt;
  logic               r_pulse, w_pulse_nxt;
  logic               r_perr,  w_perr_nxt;

  logic w_active;
  logic w_inc_fetch;
  logic w_inc_br;
  logic w_inc_miss;

  assign w_active    = (r_state != ST_DONE);
  // The halt self-loop refetches HALT every cycle; only its first fetch counts.
  assign w_inc_fetch = w_active && (instr_i != NOP_INSN) &&
                       !((r_state == ST_DRAIN) && (instr_i == HALT_INSN));
  assign w_inc_br    = w_active && br_instr_i;
  assign w_inc_miss  = w_inc_br && br_miss_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_state <= ST_RUN;
      r_drain <= '0;
      r_pulse <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= w_drain_nxt;
      r_pulse <= w_pulse_nxt;
      r_perr  <= w_perr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain;
    w_pulse_nxt = 1'b0;
    w_perr_nxt  = r_perr | (w_active & br_miss_i & ~br_instr_i);
    case (r_state)
      ST_RUN: begin
        if (instr_i == HALT_INSN) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = c_DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (r_drain == '0) begin
          w_state_nxt = ST_DONE;
          w_pulse_nxt = 1'b1;
        end else begin
          w_drain_nxt = r_drain - c_DRN_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  br_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .inc_i(w_active),    .cnt_o(cycle_cnt_o)
  );
  br_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_fetch_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .inc_i(w_inc_fetch), .cnt_o(fetch_cnt_o)
  );
  br_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_br_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .inc_i(w_inc_br),    .cnt_o(br_cnt_o)
  );
  br_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .inc_i(w_inc_miss),  .cnt_o(miss_cnt_o)
  );

  assign busy_o       = w_active;
  assign done_o       = (r_state == ST_DONE);
  assign done_pulse_o = r_pulse;
  assign proto_err_o  = r_perr;

`ifdef MISS_HIST_EN
  localparam int c_HW = hist_idx_w(MISS_DEPTH);

  logic [31:0]   r_hist_mem [MISS_DEPTH];
  logic [c_HW-1:0] r_wr_ptr;
  logic [c_HW:0]   r_hist_cnt;
  logic [c_HW-1:0] w_rd_ptr;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_wr_ptr   <= '0;
      r_hist_cnt <= '0;
    end else if (w_inc_miss) begin
      r_wr_ptr <= r_wr_ptr + c_HW'(1);
      if (r_hist_cnt != (c_HW + 1)'(MISS_DEPTH)) begin
        r_hist_cnt <= r_hist_cnt + (c_HW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !clr_i && w_inc_miss) begin
      r_hist_mem[r_wr_ptr] <= t_instr_i;
    end
  end

  // Depth is a power of two, so pointer arithmetic wraps naturally.
  assign w_rd_ptr   = r_wr_ptr - c_HW'(1) - hist_idx_i;
  assign hist_pc_o  = r_hist_mem[w_rd_ptr];
  assign hist_vld_o = ({1'b0, hist_idx_i} < r_hist_cnt);
`else
  localparam int c_unused_depth = MISS_DEPTH;
  logic w_unused_pc;
  assign w_unused_pc = ^t_instr_i;
`endif

endmodule

`default_nettype wire

// File: tb/tb_br_stat_monitor.sv
// +----------------------------------------------------------------------+
// | tb_br_stat_monitor                                                   |
// | Scoreboard bench: a cycle model pushes expectations, compared after  |
// | each clock edge for a 32-bit and a 4-bit counter instance.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_br_stat_monitor;

  localparam logic [31:0] c_HALT  = 32'h0000_006F;
  localparam logic [31:0] c_NOP   = 32'h0000_0013;
  localparam logic [31:0] c_ADDI  = 32'h0010_8093;
  localparam int          c_DRAIN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, clr_i, br_miss_i, br_instr_i;
  logic [31:0] instr_i, t_instr_i;

  logic [31:0] cyc32, fet32, br32, mis32;
  logic [3:0]  cyc4, fet4, br4, mis4;
  logic        busy32, done32, pulse32, perr32;
  logic        busy4, done4, pulse4, perr4;
`ifdef MISS_HIST_EN
  logic [2:0]  hist_idx_i;
  logic [31:0] hist_pc32, hist_pc4;
  logic        hist_vld32, hist_vld4;
`endif

  br_stat_monitor #(.CNT_WIDTH(32)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .br_miss_i(br_miss_i),
    .br_instr_i(br_instr_i), .instr_i(instr_i), .t_instr_i(t_instr_i),
    .cycle_cnt_o(cyc32), .fetch_cnt_o(fet32), .br_cnt_o(br32), .miss_cnt_o(mis32),
    .busy_o(busy32), .done_o(done32), .done_pulse_o(pulse32),
`ifdef MISS_HIST_EN
    .hist_idx_i(hist_idx_i), .hist_pc_o(hist_pc32), .hist_vld_o(hist_vld32),
`endif
    .proto_err_o(perr32)
  );

  br_stat_monitor #(.CNT_WIDTH(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .br_miss_i(br_miss_i),
    .br_instr_i(br_instr_i), .instr_i(instr_i), .t_instr_i(t_instr_i),
    .cycle_cnt_o(cyc4), .fetch_cnt_o(fet4), .br_cnt_o(br4), .miss_cnt_o(mis4),
    .busy_o(busy4), .done_o(done4), .done_pulse_o(pulse4),
`ifdef MISS_HIST_EN
    .hist_idx_i(hist_idx_i), .hist_pc_o(hist_pc4), .hist_vld_o(hist_vld4),
`endif
    .proto_err_o(perr4)
  );

  typedef struct {
    longint cyc, fet, br, mis;
    bit     busy, done, pulse, perr;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  int          m_st;
  int          m_drn;
  longint      m_cyc, m_fet, m_br, m_mis;
  bit          m_perr, m_pulse;
  logic [31:0] m_hist[$];

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic longint lim15(input longint v);
    return (v > 15) ? 64'd15 : v;
  endfunction

  task automatic cyc(input bit rst, input bit clr, input bit miss, input bit br,
                     input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    rst_i = rst; clr_i = clr; br_miss_i = miss; br_instr_i = br;
    instr_i = ins; t_instr_i = pc;
    if (rst || clr) begin
      m_st = 0; m_drn = 0; m_cyc = 0; m_fet = 0; m_br = 0; m_mis = 0;
      m_perr = 1'b0; m_pulse = 1'b0;
      m_hist.delete();
    end else if (m_st != 2) begin
      m_cyc++;
      if (ins != c_NOP && !(m_st == 1 && ins == c_HALT)) m_fet++;
      if (br) m_br++;
      if (br && miss) begin
        m_mis++;
        m_hist.push_back(pc);
      end
      if (miss && !br) m_perr = 1'b1;
      m_pulse = 1'b0;
      if (m_st == 0 && ins == c_HALT) begin
        m_st = 1; m_drn = c_DRAIN - 1;
      end else if (m_st == 1) begin
        if (m_drn == 0) begin
          m_st = 2; m_pulse = 1'b1;
        end else begin
          m_drn--;
        end
      end
    end else begin
      m_pulse = 1'b0;
    end
    e.cyc = m_cyc; e.fet = m_fet; e.br = m_br; e.mis = m_mis;
    e.busy = (m_st != 2); e.done = (m_st == 2); e.pulse = m_pulse; e.perr = m_perr;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("cycle_cnt",  cyc32,   e.cyc);
    chk("fetch_cnt",  fet32,   e.fet);
    chk("br_cnt",     br32,    e.br);
    chk("miss_cnt",   mis32,   e.mis);
    chk("busy",       busy32,  e.busy);
    chk("done",       done32,  e.done);
    chk("done_pulse", pulse32, e.pulse);
    chk("proto_err",  perr32,  e.perr);
    chk("cycle_cnt4", cyc4,    lim15(e.cyc));
    chk("fetch_cnt4", fet4,    lim15(e.fet));
    chk("br_cnt4",    br4,     lim15(e.br));
    chk("miss_cnt4",  mis4,    lim15(e.mis));
    chk("done4",      done4,   e.done);
  endtask

  initial begin
`ifdef MISS_HIST_EN
    hist_idx_i = '0;
`endif
    cyc(1, 0, 0, 0, c_NOP, 32'h0);
    cyc(1, 0, 0, 0, c_NOP, 32'h0);

    // Program run: 4 branches, 2 of them mispredicted, then halt.
    for (int i = 0; i < 10; i++)
      cyc(0, 0, (i == 1 || i == 5), (i == 1 || i == 3 || i == 5 || i == 7), c_ADDI, 32'h200 + 4 * i);
    cyc(0, 0, 0, 0, c_HALT, 32'h0);
    for (int i = 0; i < c_DRAIN; i++) cyc(0, 0, 0, 0, c_HALT, 32'h0);
    chk("run_done",  done32,      1);
    chk("run_br",    br32,        4);
    chk("run_miss",  mis32,       2);
    chk("run_cycle", cyc32,       15);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, c_ADDI, 32'h0);
    chk("frozen_br", br32, 4);
    chk("pulse_gone", pulse32, 0);

    // Saturation on the 4-bit instance.
    cyc(0, 1, 0, 0, c_NOP, 32'h0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 1, c_ADDI, 32'h300);
    chk("sat_br4",   br4,  15);
    chk("sat_miss4", mis4, 15);

    // Miss strobe without a branch.
    cyc(0, 1, 0, 0, c_NOP, 32'h0);
    cyc(0, 0, 1, 0, c_ADDI, 32'h0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, c_ADDI, 32'h0);
    chk("perr_set",  perr32, 1);
    chk("perr_miss", mis32,  0);
    cyc(0, 1, 0, 0, c_NOP, 32'h0);
    chk("perr_clr",  perr32, 0);

    // Reset on the second DRAIN cycle.
    cyc(0, 0, 1, 1, c_ADDI, 32'h0);
    cyc(0, 0, 0, 0, c_HALT, 32'h0);
    cyc(0, 0, 0, 0, c_HALT, 32'h0);
    cyc(1, 0, 0, 1, c_HALT, 32'h0);
    chk("rst_busy", busy32, 1);
    chk("rst_br",   br32,   0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, c_ADDI, 32'h0);
    chk("rst_nodone", done32, 0);

    // Fetch stream with NOPs and repeated halt fetches.
    cyc(0, 1, 0, 0, c_NOP, 32'h0);
    cyc(0, 0, 0, 0, c_NOP, 32'h0);
    cyc(0, 0, 0, 0, c_NOP, 32'h0);
    cyc(0, 0, 0, 0, c_ADDI, 32'h0);
    cyc(0, 0, 0, 0, c_HALT, 32'h0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, c_HALT, 32'h0);
    chk("fetch_done", done32, 1);
    chk("fetch_cnt_end", fet32, 2);

`ifdef MISS_HIST_EN
    cyc(0, 1, 0, 0, c_NOP, 32'h0);
    chk("hist_empty_vld", hist_vld32, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1, c_ADDI, 32'h100 + 4 * i);
    for (int k = 0; k < 8; k++) begin
      hist_idx_i = 3'(k);
      #1;
      chk("hist_vld", hist_vld32, (k < ((m_hist.size() < 8) ? m_hist.size() : 8)));
      chk("hist_pc",  hist_pc32,  m_hist[m_hist.size() - 1 - k]);
    end
    hist_idx_i = 3'd0;
    #0;
    chk("hist_idx0", hist_pc32, 32'h124);
    hist_idx_i = 3'd7;
    #0;
    chk("hist_idx7", hist_pc32, 32'h108);
    hist_idx_i = 3'd0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/br_stat_monitor.md
Name: br_stat_monitor

Overview:
Downstream consumer of the core wrapper's branch-observation signals (branch-miss strobe, branch-resolved strobe, fetched instruction, EX/MEM branch PC). Accumulates saturating performance counters over one program run and detects program end from the fetched instruction stream. Freezes results and reports completion, so the bench can compute misprediction rate per predictor variant. Sits in the testbench hierarchy, clocked with the core.

Parameters:
CNT_WIDTH, 32, width of every statistics counter
HALT_INSN, 32'h0000_006F, fetched encoding that marks program end (jal x0,0 self-loop)
NOP_INSN, 32'h0000_0013, fetched encoding excluded from fetch count (addi x0,x0,0)
DRAIN_CYCLES, 4, cycles kept counting after halt detection so in-flight branches resolve
MISS_DEPTH, 8, entries in the optional miss-PC history (power of two, >=2)

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous active-high reset
clr_i  in  1  synchronous clear: zero counters, restart in RUN
br_miss_i  in  1  mispredict strobe for the branch in EX/MEM
br_instr_i  in  1  branch/jump present in EX/MEM
instr_i  in  32  instruction currently fetched
t_instr_i  in  32  PC of EX/MEM branch
cycle_cnt_o  out  CNT_WIDTH  cycles spent in RUN+DRAIN
fetch_cnt_o  out  CNT_WIDTH  fetched instructions other than NOP_INSN
br_cnt_o  out  CNT_WIDTH  resolved branches
miss_cnt_o  out  CNT_WIDTH  mispredicted branches
busy_o  out  1  high in RUN or DRAIN
done_o  out  1  level, high in DONE
done_pulse_o  out  1  one-cycle pulse on entry to DONE
proto_err_o  out  1  sticky: br_miss_i seen with br_instr_i low

Behaviour:
- Reset (rst_i=1): state RUN, all counters 0, done_o/done_pulse_o/proto_err_o 0, busy_o 1 on first cycle after reset release. Reset has priority over clr_i and over every event, including mid-DRAIN.
- States: RUN -> DRAIN when instr_i==HALT_INSN (halt cycle itself still counted); DRAIN -> DONE after DRAIN_CYCLES cycles in DRAIN (internal down-counter, loaded DRAIN_CYCLES-1 on entry, exit when 0); DONE holds until rst_i or clr_i. HALT_INSN seen again during DRAIN: ignored, no reload.
- Counting (RUN and DRAIN only, registered, visible next cycle): cycle_cnt +1 every cycle; fetch_cnt +1 when instr_i!=NOP_INSN and instr_i!=HALT_INSN during DRAIN (halt self-loop refetches not counted after first); br_cnt +1 when br_instr_i; miss_cnt +1 when br_instr_i & br_miss_i.
- br_miss_i & !br_instr_i: miss not counted, proto_err_o set and held until rst_i/clr_i.
- All counters saturate at all-ones; no wrap. Invariant miss_cnt_o <= br_cnt_o.
- DONE: counters frozen, inputs ignored. done_pulse_o high exactly one cycle (the first DONE cycle).
- clr_i: next cycle same as post-reset (RUN, zeros, flags 0); event on the clr_i cycle not counted.

Optional Feature:
MISS_HIST_EN. Defined: adds ports hist_idx_i (in, $clog2(MISS_DEPTH)), hist_pc_o (out, 32), hist_vld_o (out, 1); ring buffer records t_instr_i on every counted miss; write pointer wraps, overwriting oldest; hist_idx_i=0 selects most recent; hist_vld_o=1 iff hist_idx_i < min(misses recorded, MISS_DEPTH); read is combinational from registered storage; buffer frozen in DONE, cleared (valid count 0) by rst_i/clr_i. Undefined: ports and storage absent, all other behaviour identical.

Decomposition:
- Package br_stat_pkg: state enum (RUN, DRAIN, DONE), default HALT/NOP encodings, history index width function.
- Sub-module br_sat_counter (CNT_WIDTH; ports clk_i, rst_i, clr_i, inc_i, cnt_o), instantiated four times.

Test Plan:
- 10 RUN cycles, br_instr_i on 4, br_miss_i with 2 of them, then HALT_INSN -> DRAIN 4 cycles, done_pulse_o one cycle; br_cnt_o=4, miss_cnt_o=2, cycle_cnt_o=15.
- CNT_WIDTH=4, 20 consecutive branch+miss cycles -> br_cnt_o=miss_cnt_o=15, stay 15.
- br_miss_i=1, br_instr_i=0 once -> miss_cnt_o unchanged, proto_err_o=1 until clr_i.
- rst_i asserted on 2nd DRAIN cycle -> next cycle RUN, counters 0, done_o never asserts.
- Stream NOP,NOP,addi x1,x1,1,HALT,HALT x4 -> fetch_cnt_o=2 at DONE.
- MISS_HIST_EN, MISS_DEPTH=8, 10 misses at PCs 0x100..0x124 step 4 -> idx0=0x124, idx7=0x108, hist_vld_o=1 for all idx.
